div_pre_norm: RTL and testbench
===============================

// Module: div_pre_norm
// PURPOSE
//  Input-side normaliser for the FP divider, the counterpart of the post-divide normaliser.
//  Takes one raw IEEE operand (biased exponent + stored fraction) and classifies it.
//  Restores the hidden bit and returns {exponent, mantissa} with mantissa MSB = 1.
//  Subnormals are normalised iteratively, one left shift per cycle, ahead of the mantissa divider.
// PARAMETERS
//  EXP_WIDTH   11  biased exponent width
//  MANT_WIDTH  52  stored fraction width (hidden bit excluded)
// PORTS
//  clk          in   1              single clock, rising edge
//  rst_n        in   1              synchronous reset, active low
//  in_Valid     in   1              operand present on in_Exp/in_Mant
//  out_Ready    out  1              block can accept an operand
//  in_Exp       in   EXP_WIDTH      biased exponent
//  in_Mant      in   MANT_WIDTH     stored fraction
//  out_Valid    out  1              result held on outputs
//  in_Ready     in   1              downstream takes result
//  out_Exp      out  EXP_WIDTH+1    two's-complement effective biased exponent
//  out_Mant     out  MANT_WIDTH+1   mantissa incl. hidden bit [MANT_WIDTH]
//  out_Zero     out  1              operand was +/-0
//  out_Special  out  1              exponent all ones (Inf/NaN)
//  out_Sub      out  1              operand was subnormal
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE; all out_* registers 0; out_Ready=1 after the reset edge.
//  Reset asserted mid-operation aborts the operation. No result is produced for it.
//  Handshake: accept on posedge with in_Valid & out_Ready. Deliver on posedge with out_Valid & in_Ready.
//  States:
//  - IDLE: out_Ready=1, out_Valid=0. On accept, classify the operand:
//    - exp==0, frac==0: Zero. Exp=0, Mant=0, out_Zero=1 -> DONE.
//    - exp==all ones: Special. Exp={0,in_Exp}, Mant={1,frac}, out_Special=1 -> DONE.
//    - exp!=0 otherwise: Normal. Exp={0,in_Exp}, Mant={1,frac} -> DONE.
//    - exp==0, frac!=0: Subnormal. Exp=1, Mant={0,frac}, out_Sub=1 -> SHIFT.
//  - SHIFT: out_Ready=0, out_Valid=0. Each cycle: Mant<<=1, Exp-=1 (signed, no wrap within range).
//    - Go to DONE on the edge where the shifted Mant[MANT_WIDTH] becomes 1.
//  - DONE: out_Valid=1, out_Ready=0. All outputs held stable until in_Ready=1.
//    - On in_Ready -> IDLE; out_Valid falls next cycle.
//    - in_Valid is ignored while the block is not in IDLE.
//  Latency (accept edge to out_Valid high):
//  - Zero, Normal, Special: 1 cycle.
//  - Subnormal: 1+k cycles, k = MANT_WIDTH - (index of highest set fraction bit), 1..MANT_WIDTH.
//  Exp range: min = 1-MANT_WIDTH (-51 for the defaults). EXP_WIDTH+1 bits cover it without overflow.
//  Throughput: at most one operand per 2 cycles (IDLE and DONE are never overlapped).
//  Flags are mutually exclusive. Flags and Exp/Mant change only on the load and SHIFT edges.
// TESTING (defaults EXP_WIDTH=11, MANT_WIDTH=52)
//  1. in_Exp=0x3FF, in_Mant=0
//     -> out_Valid 1 cycle after accept; out_Exp=0x3FF, out_Mant=0x10000000000000; all flags 0.
//  2. in_Exp=0, in_Mant=1 (minimum subnormal)
//     -> out_Valid 53 cycles after accept; out_Exp=0xFCD (-51), out_Mant=0x10000000000000, out_Sub=1.
//  3. in_Exp=0, in_Mant=0x8000000000000
//     -> latency 2; out_Exp=0x000, out_Mant=0x10000000000000, out_Sub=1.
//  4. Special and zero operands:
//     - in_Exp=0x7FF, in_Mant=0 -> latency 1; out_Special=1, out_Exp=0x7FF, out_Mant=0x10000000000000.
//     - in_Exp=0, in_Mant=0 -> out_Zero=1, out_Exp=0, out_Mant=0.
//  5. Hold in_Ready=0 for 5 cycles in DONE while pulsing in_Valid with new data
//     -> outputs stable, out_Ready=0, new data not captured.
//     -> release in_Ready: IDLE next cycle, out_Ready=1.
//  6. Start in_Mant=1 subnormal, drop rst_n after 10 SHIFT cycles
//     -> next cycle out_Valid=0, out_Ready=1, all outputs 0; a following normal operand completes in 1 cycle.

Source files
------------

// File: rtl/div_pre_norm.sv
// Input-side normaliser for the FP divider: classifies one raw IEEE operand and returns
// {effective exponent, mantissa with MSB set}, left-shifting subnormals one bit per cycle.
module div_pre_norm #(
   parameter int EXP_WIDTH  = 11,
   parameter int MANT_WIDTH = 52
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_Valid,
   output logic                  out_Ready,
   input  logic [EXP_WIDTH-1:0]  in_Exp,
   input  logic [MANT_WIDTH-1:0] in_Mant,
   output logic                  out_Valid,
   input  logic                  in_Ready,
   output logic [EXP_WIDTH:0]    out_Exp,
   output logic [MANT_WIDTH:0]   out_Mant,
   output logic                  out_Zero,
   output logic                  out_Special,
   output logic                  out_Sub,
   output logic [1:0]            dbg_state
);

   // Handshake: an operand is taken on a rising edge with in_Valid & out_Ready; a result is
   // released on a rising edge with out_Valid & in_Ready. Neither side may retract while waiting.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [EXP_WIDTH:0] EXP_ONE = {{EXP_WIDTH{1'b0}}, 1'b1};

   state_t                state;
   logic   [MANT_WIDTH:0] mant_shl;

   assign mant_shl  = {out_Mant[MANT_WIDTH-1:0], 1'b0};
   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         out_Ready   <= 1'b1;
         out_Valid   <= 1'b0;
         out_Exp     <= '0;
         out_Mant    <= '0;
         out_Zero    <= 1'b0;
         out_Special <= 1'b0;
         out_Sub     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_Valid) begin
                  out_Ready   <= 1'b0;
                  out_Zero    <= 1'b0;
                  out_Special <= 1'b0;
                  out_Sub     <= 1'b0;
                  if (in_Exp == '0 && in_Mant == '0) begin
                     out_Exp   <= '0;
                     out_Mant  <= '0;
                     out_Zero  <= 1'b1;
                     out_Valid <= 1'b1;
                     state     <= DONE;
                  end else if (in_Exp == '0) begin
                     // Subnormal: effective exponent starts at 1, hidden bit is 0.
                     out_Exp  <= EXP_ONE;
                     out_Mant <= {1'b0, in_Mant};
                     out_Sub  <= 1'b1;
                     state    <= SHIFT;
                  end else begin
                     out_Exp     <= {1'b0, in_Exp};
                     out_Mant    <= {1'b1, in_Mant};
                     out_Special <= &in_Exp;
                     out_Valid   <= 1'b1;
                     state       <= DONE;
                  end
               end
            end
            SHIFT: begin
               out_Mant <= mant_shl;
               out_Exp  <= out_Exp - EXP_ONE;
               if (mant_shl[MANT_WIDTH]) begin
                  out_Valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (in_Ready) begin
                  out_Valid <= 1'b0;
                  out_Ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               out_Valid <= 1'b0;
               out_Ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_pre_norm.sv
// Bench for div_pre_norm: directed cases plus random operands scored against an
// arithmetic reference model (leading-one search, shift count, exponent adjustment).
module tb_div_pre_norm;

   localparam int EW = 11;
   localparam int MW = 52;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_Valid;
   logic          out_Ready;
   logic [EW-1:0] in_Exp;
   logic [MW-1:0] in_Mant;
   logic          out_Valid;
   logic          in_Ready;
   logic [EW:0]   out_Exp;
   logic [MW:0]   out_Mant;
   logic          out_Zero;
   logic          out_Special;
   logic          out_Sub;
   logic [1:0]    dbg_state;

   int n_vec = 0;
   int n_err = 0;

   logic [EW+MW+4:0] exp_q[$];

   div_pre_norm #(.EXP_WIDTH(EW), .MANT_WIDTH(MW)) dut (
      .clk(clk), .rst_n(rst_n), .in_Valid(in_Valid), .out_Ready(out_Ready),
      .in_Exp(in_Exp), .in_Mant(in_Mant), .out_Valid(out_Valid), .in_Ready(in_Ready),
      .out_Exp(out_Exp), .out_Mant(out_Mant), .out_Zero(out_Zero),
      .out_Special(out_Special), .out_Sub(out_Sub), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: {exp, mant, zero, special, sub}; lat = edges from accept (inclusive) to out_Valid.
   function automatic logic [EW+MW+4:0] model(input logic [EW-1:0] e, input logic [MW-1:0] f,
                                               output int lat);
      logic [EW:0] xe;
      logic [MW:0] xm;
      logic        z, s, u;
      int          h, k;
      xe = '0; xm = '0; z = 0; s = 0; u = 0; lat = 1;
      if (e == 0 && f == 0) begin
         z = 1;
      end else if (e == 0) begin
         h = -1;
         for (int i = 0; i < MW; i++) if (f[i]) h = i;
         k   = MW - h;
         xm  = {1'b0, f} << k;
         xe  = (EW+1)'(1 - k);
         u   = 1;
         lat = 1 + k;
      end else begin
         xe = {1'b0, e};
         xm = {1'b1, f};
         s  = (e == {EW{1'b1}});
      end
      return {xe, xm, z, s, u};
   endfunction

   task automatic check_result(input string tag);
      logic [EW+MW+4:0] r;
      if (exp_q.size() == 0) begin
         check({tag, "_queue"}, 64'd0, 64'd1);
         return;
      end
      r = exp_q.pop_front();
      check({tag, "_exp"},  64'(out_Exp),     64'(r[EW+MW+4:MW+4]));
      check({tag, "_mant"}, 64'(out_Mant),    64'(r[MW+3:3]));
      check({tag, "_zero"}, 64'(out_Zero),    64'(r[2]));
      check({tag, "_spec"}, 64'(out_Special), 64'(r[1]));
      check({tag, "_sub"},  64'(out_Sub),     64'(r[0]));
   endtask

   // Offer one operand, wait for the result, stall in_Ready for 'stall' cycles, then release.
   task automatic drive_op(input string tag, input logic [EW-1:0] e, input logic [MW-1:0] f,
                           input int stall);
      int          lat, exp_lat, w;
      logic [EW:0] held_exp;
      logic [MW:0] held_mant;
      @(negedge clk);
      w = 0;
      while (!out_Ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      check({tag, "_ready_in"}, 64'(out_Ready), 64'd1);
      exp_q.push_back(model(e, f, exp_lat));
      in_Valid = 1'b1;
      in_Exp   = e;
      in_Mant  = f;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      in_Valid = 1'b0;
      in_Exp   = EW'($urandom);
      in_Mant  = {20'($urandom), $urandom};
      while (!out_Valid && lat < 200) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      check_result(tag);
      held_exp  = out_Exp;
      held_mant = out_Mant;
      for (int i = 0; i < stall; i++) begin
         in_Valid = 1'($urandom);
         in_Exp   = EW'($urandom);
         in_Mant  = {20'($urandom), $urandom};
         @(posedge clk);
         @(negedge clk);
         check({tag, "_stall_valid"}, 64'(out_Valid), 64'd1);
         check({tag, "_stall_ready"}, 64'(out_Ready), 64'd0);
         check({tag, "_stall_exp"},   64'(out_Exp),   64'(held_exp));
         check({tag, "_stall_mant"},  64'(out_Mant),  64'(held_mant));
      end
      in_Valid = 1'b0;
      in_Ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_Ready = 1'b0;
      check({tag, "_rel_valid"}, 64'(out_Valid), 64'd0);
      check({tag, "_rel_ready"}, 64'(out_Ready), 64'd1);
      check({tag, "_rel_mant"},  64'(out_Mant),  64'(held_mant));
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_valid"}, 64'(out_Valid), 64'd0);
      check({tag, "_ready"}, 64'(out_Ready), 64'd1);
      check({tag, "_exp"},   64'(out_Exp),   64'd0);
      check({tag, "_mant"},  64'(out_Mant),  64'd0);
      check({tag, "_flags"}, 64'({out_Zero, out_Special, out_Sub}), 64'd0);
   endtask

   initial begin
      logic [MW-1:0] f;
      logic [EW-1:0] e;
      int            cls;

      rst_n    = 1'b0;
      in_Valid = 1'b0;
      in_Ready = 1'b0;
      in_Exp   = '0;
      in_Mant  = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_cleared("reset");
      rst_n = 1'b1;

      drive_op("normal_one", 11'h3FF, '0, 0);
      drive_op("sub_min",    '0, 52'd1, 0);
      drive_op("sub_top",    '0, 52'h8000000000000, 0);
      drive_op("inf",        11'h7FF, '0, 0);
      drive_op("nan",        11'h7FF, 52'h0000000000123, 1);
      drive_op("zero",       '0, '0, 0);
      drive_op("stall5",     11'h400, 52'hABCDE12345678, 5);

      // Reset during a long shift sequence aborts it.
      @(negedge clk);
      in_Valid = 1'b1;
      in_Exp   = '0;
      in_Mant  = 52'd1;
      @(posedge clk);
      @(negedge clk);
      in_Valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("abort_busy", 64'(out_Ready), 64'd0);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_cleared("abort");
      rst_n = 1'b1;
      drive_op("after_abort", 11'h123, 52'h0F0F0F0F0F0F0, 0);

      for (int n = 0; n < 40; n++) begin
         cls = $urandom_range(0, 3);
         f   = {20'($urandom), $urandom};
         case (cls)
            0: begin e = '0; f = '0; end
            1: begin
               e = '0;
               f = f >> $urandom_range(0, MW - 1);
               if (f == '0) f = 52'd1;
            end
            2: e = EW'($urandom_range(1, (1 << EW) - 2));
            default: e = {EW{1'b1}};
         endcase
         drive_op("rand", e, f, $urandom_range(0, 3));
      end

      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
